// File: rtl/instr_sequencer_pkg.sv
// Shared types and constants for the multi-cycle instruction sequencer.
package instr_sequencer_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_HALT,
        S_ERROR
    } seq_state_t;

    typedef logic [1:0] pc_sel_t;

    localparam pc_sel_t PC_PLUS4  = 2'd0;
    localparam pc_sel_t PC_BRANCH = 2'd1;
    localparam pc_sel_t PC_JUMP   = 2'd2;

    // Next-PC source at writeback; a jump overrides any branch outcome.
    function automatic pc_sel_t wb_pc_sel(input logic is_jump, input logic is_branch,
                                          input logic taken);
        if (is_jump) begin
            return PC_JUMP;
        end else if (is_branch && taken) begin
            return PC_BRANCH;
        end
        return PC_PLUS4;
    endfunction

endpackage

// File: rtl/instr_sequencer_mem_wait_timer.sv
// Counts consecutive ready-low cycles of a memory wait state; term flags the last
// cycle that may still be waited before the access is declared failed.
module instr_sequencer_mem_wait_timer #(
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic term
);

    localparam int unsigned W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

    logic [W-1:0] cnt_q;

    // Wait counter: clear has priority over count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (en) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign term = (cnt_q == W'(MEM_TIMEOUT - 1));

endmodule

// File: rtl/instr_sequencer.sv
// Multi-cycle sequencer for the single-issue datapath: fetch, decode, execute,
// optional memory access, writeback, with halt and memory-stall timeout handling.
module instr_sequencer
    import instr_sequencer_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             reg_write,
    input  logic             mem_read,
    input  logic             mem_write,
    input  logic             is_jump,
    input  logic             is_branch,
    input  logic             branch_taken,
    input  logic             halt_req,
    input  logic             imem_ready,
    input  logic             dmem_ready,
    output logic             imem_req,
    output logic             ir_load,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic             rf_we,
    output logic             pc_en,
    output logic [1:0]       pc_sel,
    output logic             halted,
    output logic             err,
    output logic [CNT_W-1:0] retired
);

    seq_state_t       state_q, state_d;
    logic [CNT_W-1:0] retired_q;
    logic             tmr_clr, tmr_en, tmr_term;

    // Any state change restarts the wait count, so each FETCH/MEM visit starts at zero.
    assign tmr_clr = (state_d != state_q);
    assign tmr_en  = ((state_q == S_FETCH) && !imem_ready) ||
                     ((state_q == S_MEM) && !dmem_ready);

    instr_sequencer_mem_wait_timer #(
        .MEM_TIMEOUT(MEM_TIMEOUT)
    ) u_mem_wait_timer (
        .clk (clk),
        .rst (rst),
        .clr (tmr_clr),
        .en  (tmr_en),
        .term(tmr_term)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode; ready is checked before the timeout so a late ack still completes.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:   state_d = S_FETCH;
            S_FETCH: begin
                if (imem_ready) begin
                    state_d = S_DECODE;
                end else if (tmr_term) begin
                    state_d = S_ERROR;
                end
            end
            S_DECODE: state_d = S_EXEC;
            S_EXEC:   state_d = (mem_read || mem_write) ? S_MEM : S_WB;
            S_MEM: begin
                if (dmem_ready) begin
                    if (mem_write) begin
                        state_d = halt_req ? S_HALT : S_FETCH;
                    end else begin
                        state_d = S_WB;
                    end
                end else if (tmr_term) begin
                    state_d = S_ERROR;
                end
            end
            S_WB:     state_d = halt_req ? S_HALT : S_FETCH;
            S_HALT: begin
                if (!halt_req) begin
                    state_d = S_FETCH;
                end
            end
            S_ERROR:  state_d = S_ERROR;
            default:  state_d = S_IDLE;
        endcase
    end

    // Output decode from current state plus same-cycle handshake inputs.
    always_comb begin
        imem_req = 1'b0;
        ir_load  = 1'b0;
        dmem_req = 1'b0;
        dmem_we  = 1'b0;
        rf_we    = 1'b0;
        pc_en    = 1'b0;
        pc_sel   = PC_PLUS4;
        halted   = 1'b0;
        err      = 1'b0;
        unique case (state_q)
            S_FETCH: begin
                imem_req = 1'b1;
                ir_load  = imem_ready;
            end
            S_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = mem_write;
                // A store retires on its data ack; there is no writeback step.
                pc_en    = dmem_ready && mem_write;
            end
            S_WB: begin
                rf_we  = reg_write;
                pc_en  = 1'b1;
                pc_sel = wb_pc_sel(is_jump, is_branch, branch_taken);
            end
            S_HALT:  halted = 1'b1;
            S_ERROR: err    = 1'b1;
            default: ;
        endcase
    end

    // Retired-instruction counter, wraps silently.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            retired_q <= '0;
        end else if (pc_en) begin
            retired_q <= retired_q + 1'b1;
        end
    end

    assign retired = retired_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Scoreboard bench for instr_sequencer: expected retire records are queued when an
// instruction is issued and popped when the DUT pulses pc_en.
module tb_instr_sequencer;
    import instr_sequencer_pkg::*;

    localparam int unsigned MEM_TIMEOUT = 16;
    localparam int unsigned CNT_W       = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             reg_write, mem_read, mem_write, is_jump, is_branch, branch_taken;
    logic             halt_req, imem_ready, dmem_ready;
    logic             imem_req, ir_load, dmem_req, dmem_we, rf_we, pc_en;
    logic [1:0]       pc_sel;
    logic             halted, err;
    logic [CNT_W-1:0] retired;

    always #5 clk = ~clk;

    instr_sequencer #(
        .MEM_TIMEOUT(MEM_TIMEOUT),
        .CNT_W      (CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .reg_write   (reg_write),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .is_jump     (is_jump),
        .is_branch   (is_branch),
        .branch_taken(branch_taken),
        .halt_req    (halt_req),
        .imem_ready  (imem_ready),
        .dmem_ready  (dmem_ready),
        .imem_req    (imem_req),
        .ir_load     (ir_load),
        .dmem_req    (dmem_req),
        .dmem_we     (dmem_we),
        .rf_we       (rf_we),
        .pc_en       (pc_en),
        .pc_sel      (pc_sel),
        .halted      (halted),
        .err         (err),
        .retired     (retired)
    );

    typedef struct {
        logic [1:0] pc_sel;
        logic       rf_we;
        int         lat;
    } exp_t;

    exp_t             sb[$];
    int               n_vec = 0;
    int               n_err = 0;
    logic [CNT_W-1:0] ret_model = '0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] all_outs();
        return 32'({imem_req, ir_load, dmem_req, dmem_we, rf_we, pc_en, pc_sel, halted, err});
    endfunction

    // Issue one instruction; memories ack after iwait/dwait stalled request cycles.
    task automatic run_instr(input string name, input logic rw, input logic mr, input logic mw,
                             input logic jmp, input logic br, input logic tk, input logic hlt,
                             input int iwait, input int dwait);
        exp_t e;
        int   icnt = 0;
        int   dcnt = 0;
        int   cyc  = 0;
        bit   started = 0;
        bit   done = 0;
        bit   rf_seen = 0;
        reg_write = rw; mem_read = mr; mem_write = mw;
        is_jump = jmp; is_branch = br; branch_taken = tk; halt_req = hlt;
        e.pc_sel = jmp ? PC_JUMP : ((br && tk) ? PC_BRANCH : PC_PLUS4);
        e.rf_we  = rw && !mw;
        e.lat    = iwait + 3 + ((mr || mw) ? dwait + 1 : 0) + (mw ? 0 : 1);
        sb.push_back(e);
        for (int c = 0; c < 200 && !done; c++) begin
            @(negedge clk);
            if (imem_req) begin
                imem_ready = (icnt == iwait);
                icnt++;
            end else begin
                imem_ready = 1'b0;
            end
            if (dmem_req) begin
                dmem_ready = (dcnt == dwait);
                dcnt++;
            end else begin
                dmem_ready = 1'b0;
            end
            #1;
            if (imem_req) started = 1;
            if (started) cyc++;
            if (imem_ready) check_eq({name, ".ir_load"}, 32'(ir_load), 1);
            if (dmem_req && dmem_ready) check_eq({name, ".dmem_we"}, 32'(dmem_we), 32'(mw));
            rf_seen |= rf_we;
            if (pc_en) begin
                e = sb.pop_front();
                check_eq({name, ".pc_sel"}, 32'(pc_sel), 32'(e.pc_sel));
                check_eq({name, ".rf_we"}, 32'(rf_we), 32'(e.rf_we));
                check_eq({name, ".latency"}, cyc, e.lat);
                done = 1;
            end
        end
        if (!done) begin
            check_eq({name, ".retire_timeout"}, 0, 1);
            sb.delete();
        end else begin
            ret_model++;
        end
        check_eq({name, ".dmem_req_cycles"}, dcnt, (mr || mw) ? dwait + 1 : 0);
        check_eq({name, ".rf_we_any"}, 32'(rf_seen), 32'(rw && !mw));
        @(posedge clk);
        #1;
        check_eq({name, ".retired"}, 32'(retired), 32'(ret_model));
        if (hlt) check_eq({name, ".halted"}, 32'(halted), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got running expected done");
        $fatal(1);
    end

    initial begin
        int nreq;
        rst = 1'b1;
        {reg_write, mem_read, mem_write, is_jump, is_branch, branch_taken} = '0;
        halt_req = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check_eq("reset.outs", all_outs(), 0);
        check_eq("reset.retired", 32'(retired), 0);
        rst = 1'b0;
        #1;
        check_eq("idle.outs", all_outs(), 0);

        run_instr("add",  1, 0, 0, 0, 0, 0, 0, 0, 0);
        run_instr("lw",   1, 1, 0, 0, 0, 0, 0, 0, 3);
        run_instr("sw",   0, 0, 1, 0, 0, 0, 0, 0, 0);
        run_instr("beq",  0, 0, 0, 0, 1, 1, 0, 0, 0);
        run_instr("bne",  0, 0, 0, 0, 1, 0, 0, 0, 0);
        run_instr("addi", 1, 0, 0, 0, 0, 0, 0, 2, 0);
        for (int i = 0; i < 9; i++) begin
            int iw = $urandom_range(0, 3);
            int dw = $urandom_range(0, 3);
            case (i % 3)
                0:       run_instr("mix_alu", 1, 0, 0, 0, 0, 0, 0, iw, dw);
                1:       run_instr("mix_lw",  1, 1, 0, 0, 0, 0, 0, iw, dw);
                default: run_instr("mix_sw",  0, 0, 1, 0, 0, 0, 0, iw, dw);
            endcase
        end
        // 16th retire with CNT_W=4 wraps the counter to zero.
        run_instr("jal", 1, 0, 0, 1, 0, 0, 0, 0, 0);
        check_eq("wrap.retired", 32'(retired), 0);

        // Halt taken at the retire edge, held while halt_req stays high.
        run_instr("add_halt", 1, 0, 0, 0, 0, 0, 1, 0, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            check_eq("halt.hold", 32'({halted, imem_req}), 2);
        end
        halt_req = 1'b0;
        @(negedge clk);
        #1;
        check_eq("halt.release", 32'({halted, imem_req}), 1);
        run_instr("add_resume", 1, 0, 0, 0, 0, 0, 0, 0, 0);

        // Ack on the terminal wait cycle completes normally.
        run_instr("add_late", 1, 0, 0, 0, 0, 0, 0, MEM_TIMEOUT - 1, 0);

        // Asynchronous reset in the middle of a stalled load.
        {reg_write, mem_read, mem_write, is_jump, is_branch, branch_taken} = 6'b110000;
        nreq = 0;
        for (int c = 0; c < 40 && nreq < 3; c++) begin
            @(negedge clk);
            imem_ready = imem_req;
            dmem_ready = 1'b0;
            #1;
            if (dmem_req) nreq++;
        end
        check_eq("rstmem.reached", nreq, 3);
        #2;
        rst = 1'b1;
        #1;
        check_eq("rstmem.outs", all_outs(), 0);
        check_eq("rstmem.retired", 32'(retired), 0);
        ret_model = '0;
        imem_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_eq("rstmem.idle", all_outs(), 0);
        @(negedge clk);
        #1;
        check_eq("rstmem.fetch", 32'(imem_req), 1);

        // Instruction memory never acks: error after MEM_TIMEOUT low cycles.
        {reg_write, mem_read, mem_write, is_jump, is_branch, branch_taken} = 6'b100000;
        nreq = 1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            #1;
            if (!imem_req) break;
            nreq++;
        end
        check_eq("timeout.stall_cycles", nreq, MEM_TIMEOUT);
        check_eq("timeout.outs", all_outs(), 1);
        imem_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check_eq("timeout.sticky", all_outs(), 1);
        rst = 1'b1;
        #1;
        check_eq("timeout.rst_clears", all_outs(), 0);
        rst = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
